// File: rtl/fifo_detr.sv
// fifo_detr: serial-in/parallel-out collector that drops DELAY leading pads and assembles DEPTH elements.
// Optional pad check is built in when FIFO_DETR_PAD_CHECK_EN is defined; otherwise err is tied low.
module fifo_detr #(
    parameter int DEPTH = 8,
    parameter int BITS  = 8,
    parameter int DELAY = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             ctl,
    input  logic signed [BITS-1:0] in,
    output logic signed [BITS-1:0] out [DEPTH-1:0],
    output logic                   valid,
    output logic                   done,
    output logic                   busy,
    output logic                   err
);
    localparam int MX = (DELAY > DEPTH) ? DELAY : DEPTH;
    localparam int CW = $clog2(MX + 1);
    localparam logic [CW-1:0] SKIP_LAST = CW'((DELAY > 0) ? DELAY - 1 : 0);
    localparam logic [CW-1:0] FILL_LAST = CW'(DEPTH - 1);
    typedef enum logic [1:0] {IDLE, SKIP, FILL, DONE} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    // capture FSM with registered status outputs; start wins in every state, 2'b11 is a plain hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= '{default: '0};
            valid <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ctl == 2'b01) begin
                out   <= '{default: '0};
                valid <= 1'b0;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= (DELAY > 0) ? SKIP : FILL;
            end else if (ctl == 2'b10) begin
                case (state)
                    SKIP: begin
                        cnt   <= (cnt == SKIP_LAST) ? '0 : cnt + 1'b1;
                        state <= (cnt == SKIP_LAST) ? FILL : SKIP;
                    end
                    FILL: begin
                        for (int i = 0; i < DEPTH - 1; i++) out[i] <= out[i+1];
                        out[DEPTH-1] <= in;
                        cnt <= cnt + 1'b1;
                        if (cnt == FILL_LAST) begin
                            state <= DONE;
                            valid <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`ifdef FIFO_DETR_PAD_CHECK_EN
    // sticky flag for any non-zero element discarded as a pad; only rst clears it
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if (ctl == 2'b10 && state == SKIP && in != '0) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_detr.sv
// tb_fifo_detr: directed scoreboard bench for fifo_detr (DELAY=2 and DELAY=0 instances, DEPTH=4, BITS=8).
module tb_fifo_detr;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] ctl0, ctl1;
    logic signed [7:0] in0, in1;
    logic signed [7:0] out0 [3:0];
    logic signed [7:0] out1 [3:0];
    logic valid0, done0, busy0, err0, valid1, done1, busy1, err1;
    int checks = 0;
    int errors = 0;
    int dcnt0 = 0;
    int dcnt1 = 0;
    int dmark;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] last0;
`ifdef FIFO_DETR_PAD_CHECK_EN
    localparam logic PAD_ERR = 1'b1;
`else
    localparam logic PAD_ERR = 1'b0;
`endif

    fifo_detr #(.DEPTH(4), .BITS(8), .DELAY(2)) u0 (
        .clk(clk), .rst(rst), .ctl(ctl0), .in(in0), .out(out0),
        .valid(valid0), .done(done0), .busy(busy0), .err(err0)
    );
    fifo_detr #(.DEPTH(4), .BITS(8), .DELAY(0)) u1 (
        .clk(clk), .rst(rst), .ctl(ctl1), .in(in1), .out(out1),
        .valid(valid1), .done(done1), .busy(busy1), .err(err1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic signed [7:0] o [3:0]);
        return {o[3], o[2], o[1], o[0]};
    endfunction

    function automatic logic [31:0] vec(input byte a3, input byte a2, input byte a1, input byte a0);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: inputs already applied; sample #1 after the edge and service the scoreboards
    task automatic tick();
        @(posedge clk);
        #1;
        if (done0) begin
            dcnt0++;
            if (q0.size() == 0) chk("done0_spurious", {31'b0, done0}, 32'd0);
            else chk("out0_sb", pack(out0), q0.pop_front());
        end
        if (done1) begin
            dcnt1++;
            if (q1.size() == 0) chk("done1_spurious", {31'b0, done1}, 32'd0);
            else chk("out1_sb", pack(out1), q1.pop_front());
        end
    endtask

    task automatic s0(input logic [1:0] c, input byte v);
        @(negedge clk);
        ctl0 = c; in0 = v; ctl1 = 2'b00; in1 = '0;
        tick();
    endtask

    task automatic s1(input logic [1:0] c, input byte v);
        @(negedge clk);
        ctl1 = c; in1 = v; ctl0 = 2'b00; in0 = '0;
        tick();
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1; ctl0 = 2'b00; ctl1 = 2'b00; in0 = '0; in1 = '0;
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ctl0 = 2'b00; ctl1 = 2'b00; in0 = '0; in1 = '0;
        tick();
        do_rst();
        chk("rst_out0", pack(out0), 32'd0);
        chk("rst_flags0", {valid0, done0, busy0, err0}, 4'b0000);
        chk("rst_out1", pack(out1), 32'd0);
        chk("rst_flags1", {valid1, done1, busy1, err1}, 4'b0000);

        // basic back-to-back stream
        s0(2'b01, 0);
        chk("basic_busy", busy0, 1'b1);
        s0(2'b10, 0); s0(2'b10, 0); s0(2'b10, 10); s0(2'b10, -20); s0(2'b10, 30);
        chk("basic_notvalid", valid0, 1'b0);
        chk("basic_partial", pack(out0), vec(30, -20, 10, 0));
        q0.push_back(vec(-40, 30, -20, 10));
        s0(2'b10, -40);
        chk("basic_flags", {valid0, done0, busy0}, 3'b110);
        chk("basic_out", pack(out0), vec(-40, 30, -20, 10));
        s0(2'b00, 0);
        chk("basic_done_drop", {valid0, done0}, 2'b10);

        // gapped stream plus ignored shifts after DONE
        dmark = dcnt0;
        s0(2'b01, 0);
        s0(2'b10, 0); s0(2'b00, 0); s0(2'b10, 0); s0(2'b00, 0);
        s0(2'b10, 10); s0(2'b00, 0); s0(2'b10, -20); s0(2'b00, 0);
        s0(2'b10, 30); s0(2'b00, 0); s0(2'b00, 0);
        q0.push_back(vec(-40, 30, -20, 10));
        s0(2'b10, -40);
        s0(2'b10, 99); s0(2'b10, 99); s0(2'b00, 0);
        chk("gap_out", pack(out0), vec(-40, 30, -20, 10));
        chk("gap_valid", {valid0, done0, busy0}, 3'b100);
        chk("gap_done_once", dcnt0 - dmark, 32'd1);

        // abort and restart
        dmark = dcnt0;
        s0(2'b01, 0);
        s0(2'b10, 0); s0(2'b10, 0); s0(2'b10, 5); s0(2'b10, 6);
        s0(2'b01, 0);
        chk("abort_out_zero", pack(out0), 32'd0);
        chk("abort_flags", {valid0, busy0}, 2'b01);
        s0(2'b10, 0); s0(2'b10, 0); s0(2'b10, 1); s0(2'b10, 2); s0(2'b10, 3);
        chk("abort_no_done", dcnt0 - dmark, 32'd0);
        q0.push_back(vec(4, 3, 2, 1));
        s0(2'b10, 4);
        chk("abort_out", pack(out0), vec(4, 3, 2, 1));
        chk("abort_done_once", dcnt0 - dmark, 32'd1);

        // reset in the middle of FILL
        s0(2'b01, 0);
        s0(2'b10, 0); s0(2'b10, 0); s0(2'b10, 7);
        do_rst();
        chk("midrst_out", pack(out0), 32'd0);
        chk("midrst_flags", {valid0, busy0}, 2'b00);
        s0(2'b10, 5); s0(2'b10, 5); s0(2'b10, 5); s0(2'b10, 5); s0(2'b10, 5); s0(2'b10, 5);
        chk("midrst_ignored", pack(out0), 32'd0);
        chk("midrst_idle", {valid0, busy0}, 2'b00);

        // DELAY=0 instance with a 2'b11 hold mid-stream
        s1(2'b01, 0);
        chk("d0_busy", busy1, 1'b1);
        s1(2'b10, 1); s1(2'b10, 2);
        s1(2'b11, 9);
        chk("d0_hold11", pack(out1), vec(2, 1, 0, 0));
        chk("d0_hold11_flags", {valid1, busy1}, 2'b01);
        s1(2'b10, 3);
        chk("d0_notvalid", valid1, 1'b0);
        q1.push_back(vec(4, 3, 2, 1));
        s1(2'b10, 4);
        chk("d0_out", pack(out1), vec(4, 3, 2, 1));
        chk("d0_flags", {valid1, done1, busy1}, 3'b110);

        // pad check
        s0(2'b01, 0);
        s0(2'b10, 0);
        chk("pad_clean", err0, 1'b0);
        s0(2'b10, 3);
        chk("pad_err", err0, PAD_ERR);
        s0(2'b01, 0);
        chk("pad_sticky", err0, PAD_ERR);
        do_rst();
        chk("pad_rst", err0, 1'b0);
        chk("pad_err1", err1, 1'b0);

        chk("sb_empty0", q0.size(), 32'd0);
        chk("sb_empty1", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
